// File: rtl/cpu_mc_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB
// sequencing, datapath select decode, memory handshakes and retired-instruction count.
module cpu_mc_ctrl #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          ir,
  output logic                 imem_req,
  input  logic                 imem_ack,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ack,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 rf_we,
  output logic [3:0]           alu_fun,
  output logic [1:0]           br_fun,
  output logic                 op1_sel,
  output logic [1:0]           op2_sel,
  output logic [1:0]           wb_sel,
  output logic [1:0]           pc_sel,
  output logic                 trap,
  output logic [INSTRET_W-1:0] instret,
  output logic [2:0]           fsm_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                         OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011;

  state_t state;
  logic   running;   // low until the first edge after reset so imem_req stays 0 in reset
  logic   is_mem;
  logic   is_store;
  logic   is_branch;

  logic [3:0] d_alu;
  logic [1:0] d_br;
  logic       d_op1;
  logic [1:0] d_op2;
  logic [1:0] d_wb;
  logic [1:0] d_pc;
  logic       d_ill;
  logic       d_mem;
  logic       d_store;
  logic       d_branch;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_ir_bits;

  assign opcode         = ir[6:0];
  assign funct3         = ir[14:12];
  assign funct7         = ir[31:25];
  assign unused_ir_bits = ^{ir[24:15], ir[11:7]};

  // Handshake rule: a request stays high until its ack is seen in the same cycle;
  // the ack cycle completes the transfer and the request drops on the next edge.
  assign imem_req  = running && (state == S_FETCH);
  assign ir_we     = imem_req && imem_ack;
  assign dmem_req  = (state == S_MEM);
  assign dmem_we   = dmem_req && is_store;
  assign pc_we     = (state == S_WB) || (dmem_req && is_store && dmem_ack);
  assign rf_we     = (state == S_WB) && !is_branch;
  assign trap      = (state == S_TRAP);
  assign fsm_state = state;

  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    d_alu    = ALU_ADD;
    d_br     = 2'd0;
    d_op1    = 1'b0;
    d_op2    = 2'd0;
    d_wb     = 2'd0;
    d_pc     = 2'd0;
    d_ill    = 1'b0;
    d_mem    = 1'b0;
    d_store  = 1'b0;
    d_branch = 1'b0;
    case (opcode)
      OPC_LUI:   d_wb = 2'd2;
      OPC_AUIPC: begin
        d_op1 = 1'b1;
        d_op2 = 2'd3;
      end
      OPC_JAL: begin
        d_pc = 2'd2;
        d_wb = 2'd3;
      end
      OPC_JALR: begin
        d_ill = (funct3 != 3'b000);
        d_op2 = 2'd1;
        d_pc  = 2'd3;
        d_wb  = 2'd3;
      end
      OPC_BRANCH: begin
        d_pc     = 2'd1;
        d_branch = 1'b1;
        case (funct3)
          3'b000:  d_br = 2'd0;
          3'b001:  d_br = 2'd1;
          3'b100:  d_br = 2'd2;
          3'b101:  d_br = 2'd3;
          default: d_ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d_ill = (funct3 != 3'b010);
        d_op2 = 2'd1;
        d_wb  = 2'd1;
        d_mem = 1'b1;
      end
      OPC_STORE: begin
        d_ill   = (funct3 != 3'b010);
        d_op2   = 2'd2;
        d_mem   = 1'b1;
        d_store = 1'b1;
      end
      OPC_OPIMM: begin
        d_op2 = 2'd1;
        d_alu = alu_map(funct3, (funct3 == 3'b101) && ir[30]);
        d_ill = ((funct3 == 3'b001) || (funct3 == 3'b101)) &&
                (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          d_alu = alu_map(funct3, 1'b0);
        end else if ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
          d_alu = alu_map(funct3, 1'b1);
        end else begin
          d_ill = 1'b1;
        end
      end
      default: d_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      running   <= 1'b0;
      is_mem    <= 1'b0;
      is_store  <= 1'b0;
      is_branch <= 1'b0;
      alu_fun   <= 4'd0;
      br_fun    <= 2'd0;
      op1_sel   <= 1'b0;
      op2_sel   <= 2'd0;
      wb_sel    <= 2'd0;
      pc_sel    <= 2'd0;
      instret   <= '0;
    end else begin
      running <= 1'b1;
      case (state)
        S_FETCH: if (imem_req && imem_ack) state <= S_DECODE;
        S_DECODE: begin
          if (d_ill) begin
            state <= S_TRAP;
          end else begin
            alu_fun   <= d_alu;
            br_fun    <= d_br;
            op1_sel   <= d_op1;
            op2_sel   <= d_op2;
            wb_sel    <= d_wb;
            pc_sel    <= d_pc;
            is_mem    <= d_mem;
            is_store  <= d_store;
            is_branch <= d_branch;
            state     <= S_EXEC;
          end
        end
        S_EXEC: state <= is_mem ? S_MEM : S_WB;
        S_MEM: begin
          if (dmem_ack) begin
            if (is_store) begin
              instret <= instret + INSTRET_W'(1);
              state   <= S_FETCH;
            end else begin
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          instret <= instret + INSTRET_W'(1);
          state   <= S_FETCH;
        end
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
